// File: rtl/conv_out_serializer.sv
// ============================================================================
// conv_out_serializer : buffers N_CH-wide conv vectors, emits one word/handshake
// Optional CONV_SER_DROP_CNT_EN adds a saturating drop counter.  Rev 1.0
// ============================================================================
`default_nettype none

module conv_out_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int N_CH       = 32,
  parameter int D_OUT      = 24,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [N_CH*DATA_WIDTH-1:0]   pxl_in,
  output logic [DATA_WIDTH-1:0]        pxl_out,
  output logic [$clog2(N_CH)-1:0]      ch_out,
  output logic                         valid_out,
  input  logic                         ready_out,
  output logic                         last_out,
  output logic                         overflow
`ifdef CONV_SER_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_cnt
`endif
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam int CW     = $clog2(N_CH);
  localparam int FRAMES = D_OUT * D_OUT;
  localparam int FW     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [CW-1:0] CH_LAST    = CW'(N_CH - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

  logic [N_CH*DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t                     state_q, state_d;
  logic [CW-1:0]              ch_q, ch_d;
  logic [FW-1:0]              frame_q, frame_d;
  logic                       ovf_q, ovf_d;
  logic                       empty, full, pop, push, drop;
  logic [N_CH*DATA_WIDTH-1:0] head;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop      = (state_q == SEND) && ready_out && (ch_q == CH_LAST);
    // A pop on the same edge frees the slot the incoming vector needs.
    push     = valid_in && (!full || pop);
    drop     = valid_in && !push;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ovf_d    = ovf_q | drop;
    ch_d     = ch_q;
    frame_d  = frame_q;
    state_d  = state_q;
    case (state_q)
      IDLE: if (!empty) state_d = SEND;
      SEND: begin
        if (ready_out) begin
          if (ch_q == CH_LAST) begin
            ch_d    = '0;
            frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
            if (wr_ptr_d == rd_ptr_d) state_d = IDLE;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= pxl_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      ch_q     <= '0;
      frame_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      ch_q     <= ch_d;
      frame_q  <= frame_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef CONV_SER_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_cnt_q <= 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  always_comb begin
    head    = mem_q[rd_ptr_q[AW-1:0]];
    pxl_out = '0;
    if (state_q == SEND) pxl_out = head[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH];
  end

  assign valid_out = (state_q == SEND);
  assign ch_out    = ch_q;
  assign last_out  = (state_q == SEND) && (frame_q == FRAME_LAST) && (ch_q == CH_LAST);
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_out_serializer.sv
// Directed bench for conv_out_serializer at default parameters.
`default_nettype none

module tb_conv_out_serializer;

  localparam int DW = 32;
  localparam int NC = 32;
  localparam int DO = 24;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              valid_in;
  logic [NC*DW-1:0]  pxl_in;
  logic [DW-1:0]     pxl_out;
  logic [4:0]        ch_out;
  logic              valid_out;
  logic              ready_out;
  logic              last_out;
  logic              overflow;
`ifdef CONV_SER_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  conv_out_serializer #(
    .DATA_WIDTH (DW),
    .N_CH       (NC),
    .D_OUT      (DO),
    .DEPTH      (DP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .pxl_in    (pxl_in),
    .pxl_out   (pxl_out),
    .ch_out    (ch_out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .last_out  (last_out),
    .overflow  (overflow)
`ifdef CONV_SER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] word(input int tag, input int k);
    return DW'(tag * 256 + k + 1);
  endfunction

  function automatic logic [NC*DW-1:0] mkvec(input int tag);
    logic [NC*DW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*DW +: DW] = word(tag, k);
    return v;
  endfunction

  // Expects one handshake per cycle (ready_out=1) from word index 'start'.
  task automatic stream(input int tag, input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      chk("valid", 64'(valid_out), 64'(1));
      chk("ch", 64'(ch_out), 64'(i % NC));
      chk("pxl", 64'(pxl_out), 64'(word(tag + i / NC, i % NC)));
      chk("last", 64'(last_out), 64'(0));
      @(negedge clk);
    end
  endtask

  initial begin
    int wcount, s5_err, nlast, lastpos;
    logic last577;
    reset = 1'b0; valid_in = 1'b0; ready_out = 1'b1; pxl_in = '0;
    @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'(0));
    chk("rst_ch", 64'(ch_out), 64'(0));
    chk("rst_last", 64'(last_out), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_pxl", 64'(pxl_out), 64'(0));
`ifdef CONV_SER_DROP_CNT_EN
    chk("rst_drop", 64'(drop_cnt), 64'(0));
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // single vector, channel k = k+1
    valid_in = 1'b1; pxl_in = mkvec(0);
    @(negedge clk);
    valid_in = 1'b0;
    chk("s1_latency", 64'(valid_out), 64'(0));
    @(negedge clk);
    stream(0, 0, NC);
    chk("s1_idle", 64'(valid_out), 64'(0));

    // two vectors back to back
    valid_in = 1'b1; pxl_in = mkvec(1);
    @(negedge clk);
    pxl_in = mkvec(2);
    @(negedge clk);
    valid_in = 1'b0;
    stream(1, 0, 2 * NC);
    chk("s2_idle", 64'(valid_out), 64'(0));

    // ready toggling
    valid_in = 1'b1; pxl_in = mkvec(3);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    chk("s3_ch0", 64'(ch_out), 64'(0));
    ready_out = 1'b1;
    @(negedge clk);
    chk("s3_ch1", 64'(ch_out), 64'(1));
    ready_out = 1'b0;
    @(negedge clk);
    chk("s3_hold_ch", 64'(ch_out), 64'(1));
    chk("s3_hold_pxl", 64'(pxl_out), 64'(word(3, 1)));
    chk("s3_hold_valid", 64'(valid_out), 64'(1));
    ready_out = 1'b1;
    @(negedge clk);
    chk("s3_ch2", 64'(ch_out), 64'(2));
    ready_out = 1'b0;
    @(negedge clk);
    chk("s3_hold2_ch", 64'(ch_out), 64'(2));
    chk("s3_hold2_pxl", 64'(pxl_out), 64'(word(3, 2)));
    ready_out = 1'b1;
    @(negedge clk);
    stream(3, 3, NC - 3);
    chk("s3_idle", 64'(valid_out), 64'(0));

    // overflow: 6 vectors into a 4-deep FIFO with no draining
    ready_out = 1'b0;
    for (int v = 0; v < 6; v++) begin
      if (v == 4) chk("s4_no_ovf_yet", 64'(overflow), 64'(0));
      valid_in = 1'b1; pxl_in = mkvec(10 + v);
      @(negedge clk);
    end
    valid_in = 1'b0;
    chk("s4_ovf", 64'(overflow), 64'(1));
`ifdef CONV_SER_DROP_CNT_EN
    chk("s4_drop_cnt", 64'(drop_cnt), 64'(2));
`endif
    ready_out = 1'b1;
    stream(10, 0, 4 * NC);
    chk("s4_idle", 64'(valid_out), 64'(0));
    chk("s4_ovf_sticky", 64'(overflow), 64'(1));

    // reset mid-vector
    valid_in = 1'b1; pxl_in = mkvec(20);
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    stream(20, 0, 10);
    chk("s6_pre_ch", 64'(ch_out), 64'(10));
    reset = 1'b0;
    #1;
    chk("s6_valid", 64'(valid_out), 64'(0));
    chk("s6_ch", 64'(ch_out), 64'(0));
    chk("s6_ovf", 64'(overflow), 64'(0));
    chk("s6_last", 64'(last_out), 64'(0));
    chk("s6_pxl", 64'(pxl_out), 64'(0));
`ifdef CONV_SER_DROP_CNT_EN
    chk("s6_drop", 64'(drop_cnt), 64'(0));
`endif
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("s6_no_partial", 64'(valid_out), 64'(0));

    // full frame plus one vector from a fresh frame
    wcount = 0; s5_err = 0; nlast = 0; lastpos = 0; last577 = 1'b0;
    for (int v = 0; v < DO * DO + 1; v++) begin
      valid_in = 1'b1; pxl_in = mkvec(v);
      @(negedge clk);
      valid_in = 1'b0;
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        wcount++;
        if (!valid_out || (int'(ch_out) != c) || (pxl_out != word(v, c))) s5_err++;
        if (last_out) begin
          nlast++;
          lastpos = wcount;
        end
        if (v == DO * DO && c == NC - 1) last577 = last_out;
        @(negedge clk);
      end
    end
    chk("s5_data_err", 64'(s5_err), 64'(0));
    chk("s5_last_count", 64'(nlast), 64'(1));
    chk("s5_last_pos", 64'(lastpos), 64'(18432));
    chk("s5_last_577", 64'(last577), 64'(0));
    chk("s5_idle", 64'(valid_out), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
